// File: rtl/aes_pkg.sv
// AES inverse-cipher primitives shared by the decrypt pipeline: block type,
// inverse S-box, byte-level round transforms and the stage-count helper.
package aes_pkg;
  localparam int AES_BLK_W = 128;
  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  // Index 0 is the most significant byte of the literal.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic int stage_cnt(input int nr, input int rps);
    return (nr + rps - 1) / rps;
  endfunction

  // GF(2^8) multiply by a small constant (only 4 bits needed for InvMixColumns).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // State byte (row r, col c) lives at byte index r+4c, byte 0 = MSB.
  function automatic aes_blk_t inv_shift_rows(input aes_blk_t s);
    aes_blk_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  function automatic aes_blk_t inv_sub_bytes(input aes_blk_t s);
    aes_blk_t o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    return o;
  endfunction

  function automatic aes_blk_t inv_mix_columns(input aes_blk_t s);
    aes_blk_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
        gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
        gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
        gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_dec_stage.sv
// Combinational group of N_ROUNDS inverse-cipher rounds. keys_i[128*k +: 128]
// is the round key for the k-th round of the group (already in decrypt order).
module aes_dec_stage
  import aes_pkg::*;
#(
  parameter int FIRST_ROUND = 1,
  parameter int N_ROUNDS    = 1,
  parameter bit IS_LAST     = 1'b0
) (
  input  aes_blk_t                  blk_i,
  input  logic [128*N_ROUNDS-1:0]   keys_i,
  output aes_blk_t                  blk_o
);
  if (FIRST_ROUND < 1 || N_ROUNDS < 1) begin : g_bad_cfg
    $error("aes_dec_stage: FIRST_ROUND and N_ROUNDS must be >= 1");
  end

  always_comb begin
    aes_blk_t s;
    s = blk_i;
    for (int k = 0; k < N_ROUNDS; k++) begin
      s = inv_sub_bytes(inv_shift_rows(s)) ^ keys_i[128*k +: 128];
      // The cipher's final round skips InvMixColumns.
      if (!IS_LAST || k != N_ROUNDS - 1) s = inv_mix_columns(s);
    end
    blk_o = s;
  end
endmodule

// File: rtl/aes_decrypt_pipe_param.sv
// Fully pipelined AES-128/192/256 inverse cipher, RPS rounds per register stage,
// global-stall handshake. Define AES_DEC_TAG_EN to carry a sideband tag per block.
module aes_decrypt_pipe_param
  import aes_pkg::*;
#(
  parameter int NR    = 14,
  parameter int RPS   = 1,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [128*(NR+1)-1:0] key_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AES_BLK_W-1:0]  data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_BLK_W-1:0]  data_out,
  output logic                  busy
`ifdef AES_DEC_TAG_EN
  ,
  input  logic [TAG_W-1:0]      tag_in,
  output logic [TAG_W-1:0]      tag_out
`endif
);
  localparam int S = stage_cnt(NR, RPS);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_decrypt_pipe_param: NR must be 10, 12 or 14");
  end
  if (RPS < 1 || RPS > NR) begin : g_bad_rps
    $error("aes_decrypt_pipe_param: RPS must be in 1..NR");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_decrypt_pipe_param: TAG_W must be >= 1");
  end

  aes_blk_t [S:0] blk_q, blk_d;
  logic     [S:0] vld_pipe_q;
  logic           adv;

  // Whole pipe moves as one; no bubble collapsing.
  assign adv       = !vld_pipe_q[S] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[S];
  assign data_out  = blk_q[S];
  assign busy      = |vld_pipe_q;

  // Gate idle input so junk on data_in never reaches the stage registers.
  assign blk_d[0] = in_valid ? (data_in ^ key_in[128*NR +: 128]) : '0;

  for (genvar i = 0; i < S; i++) begin : g_stage
    localparam int FR   = i*RPS + 1;
    localparam int NRND = (NR - i*RPS < RPS) ? (NR - i*RPS) : RPS;
    logic [128*NRND-1:0] keys;
    for (genvar k = 0; k < NRND; k++) begin : g_key
      assign keys[128*k +: 128] = key_in[128*(NR-FR-k) +: 128];
    end
    aes_dec_stage #(
      .FIRST_ROUND (FR),
      .N_ROUNDS    (NRND),
      .IS_LAST     (i == S-1)
    ) u_stage (
      .blk_i  (blk_q[i]),
      .keys_i (keys),
      .blk_o  (blk_d[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      blk_q      <= '0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[S-1:0], in_valid};
      blk_q      <= blk_d;
    end
  end

`ifdef AES_DEC_TAG_EN
  logic [S:0][TAG_W-1:0] tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   tag_q <= '0;
    else if (adv) tag_q <= {tag_q[S-1:0], tag_in};
  end

  assign tag_out = tag_q[S];
`endif
endmodule

// File: tb/tb_aes_decrypt_pipe_param.sv
// Directed bench for aes_decrypt_pipe_param: FIPS-197 vectors on three configs,
// streaming, random stalls and mid-flight reset, with an independent forward-cipher model.
module tb_aes_decrypt_pipe_param;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sbox [256];
  logic [15*128-1:0] ks10, ks12, ks14;

  logic rst_n;
  logic [128*15-1:0] key14;
  logic iv, ir, ov, ordy, bsy;
  logic [127:0] din, dout;
  logic [128*11-1:0] key10;
  logic iv10, ir10, ov10, bsy10;
  logic [127:0] din10, dout10;
  logic [128*13-1:0] key12;
  logic iv12, ir12, ov12, bsy12;
  logic [127:0] din12, dout12;
`ifdef AES_DEC_TAG_EN
  logic [7:0] tg_in, tg_out, tg10_out, tg12_out;
`endif

  aes_decrypt_pipe_param #(.NR(14), .RPS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_in(key14), .in_valid(iv), .in_ready(ir),
    .data_in(din), .out_valid(ov), .out_ready(ordy), .data_out(dout), .busy(bsy)
`ifdef AES_DEC_TAG_EN
    , .tag_in(tg_in), .tag_out(tg_out)
`endif
  );

  aes_decrypt_pipe_param #(.NR(10), .RPS(5)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .key_in(key10), .in_valid(iv10), .in_ready(ir10),
    .data_in(din10), .out_valid(ov10), .out_ready(1'b1), .data_out(dout10), .busy(bsy10)
`ifdef AES_DEC_TAG_EN
    , .tag_in(8'h5a), .tag_out(tg10_out)
`endif
  );

  aes_decrypt_pipe_param #(.NR(12), .RPS(5)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .key_in(key12), .in_valid(iv12), .in_ready(ir12),
    .data_in(din12), .out_valid(ov12), .out_ready(1'b1), .data_out(dout12), .busy(bsy12)
`ifdef AES_DEC_TAG_EN
    , .tag_in(8'ha5), .tag_out(tg12_out)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Key schedule; key is left-aligned in 256 bits.
  function automatic logic [15*128-1:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [15*128-1:0] ks;
    ks = '0;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // Forward cipher reference.
  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [15*128-1:0] ks, input int nr);
    logic [127:0] s, t;
    logic [7:0] a0, a1, a2, a3;
    s = pt ^ ks[127:0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
      for (int rw = 0; rw < 4; rw++)
        for (int c = 0; c < 4; c++)
          s[127-8*(rw+4*c) -: 8] = t[127-8*(rw+4*((c+rw)%4)) -: 8];
      if (r != nr)
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          s[127-32*c -: 32] = {gm(a0,8'h02)^gm(a1,8'h03)^a2^a3, a0^gm(a1,8'h02)^gm(a2,8'h03)^a3,
                               a0^a1^gm(a2,8'h02)^gm(a3,8'h03), gm(a0,8'h03)^a1^a2^gm(a3,8'h02)};
        end
      s = s ^ ks[128*r +: 128];
    end
    return s;
  endfunction

  logic [127:0] q [$];
  logic [7:0]   tq [$];
  logic [127:0] p, held, got10, got12, got14;
  int lat10, lat12, lat14, first, last, nout, drops, acc_n, stale;
  logic stalled;

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gm(inv, 8'(x));
      sbox[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    end
    ks10 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    ks12 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    ks14 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    key10 = ks10[128*11-1:0];
    key12 = ks12[128*13-1:0];
    key14 = ks14;
    rst_n = 1'b0; iv = 1'b0; din = '0; ordy = 1'b1;
    iv10 = 1'b0; din10 = '0; iv12 = 1'b0; din12 = '0;
`ifdef AES_DEC_TAG_EN
    tg_in = 8'h00;
`endif

    // Reset state
    #12;
    chk("reset out_valid", 128'(ov), 128'(0));
    chk("reset data_out", dout, '0);
    chk("reset busy", 128'(bsy), 128'(0));
    chk("reset in_ready", 128'(ir), 128'(1));
    @(negedge clk); rst_n = 1'b1;

    // FIPS-197 vectors, all three configs accepted on the same edge
    @(negedge clk);
    iv = 1'b1; din = CT14; iv10 = 1'b1; din10 = CT10; iv12 = 1'b1; din12 = CT12;
    lat10 = 0; lat12 = 0; lat14 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin iv = 1'b0; iv10 = 1'b0; iv12 = 1'b0; end
      if (ov && lat14 == 0) begin lat14 = c; got14 = dout; end
      if (ov10 && lat10 == 0) begin
        lat10 = c; got10 = dout10;
`ifdef AES_DEC_TAG_EN
        chk("tag10", 128'(tg10_out), 128'(8'h5a));
`endif
      end
      if (ov12 && lat12 == 0) begin
        lat12 = c; got12 = dout12;
`ifdef AES_DEC_TAG_EN
        chk("tag12", 128'(tg12_out), 128'(8'ha5));
`endif
      end
    end
    chk("aes128 latency", 128'(lat10), 128'(3));
    chk("aes128 pt", got10, PT);
    chk("aes192 latency", 128'(lat12), 128'(4));
    chk("aes192 pt", got12, PT);
    chk("aes256 latency", 128'(lat14), 128'(15));
    chk("aes256 pt", got14, PT);
    chk("idle busy10", 128'(bsy10), 128'(0));
    chk("idle busy12", 128'(bsy12), 128'(0));
    chk("idle ready10", 128'(ir10 & ir12), 128'(1));

    // 64 back-to-back blocks, consumer always ready
    first = -1; last = -1; nout = 0; drops = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 100; c++) begin
      if (!ir) drops++;
      if (c < 64) begin
        p = {$urandom, $urandom, $urandom, $urandom};
        iv = 1'b1; din = enc(p, ks14, 14); q.push_back(p);
      end else begin
        iv = 1'b0; din = '0;
      end
      if (ov) begin
        chk("b2b data", dout, q.pop_front());
        if (first < 0) first = c;
        last = c; nout++;
      end
      @(posedge clk); #1;
    end
    chk("b2b count", 128'(nout), 128'(64));
    chk("b2b consecutive", 128'(last - first), 128'(63));
    chk("b2b in_ready drops", 128'(drops), 128'(0));

    // Random in_valid and ~30% backpressure
    acc_n = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 400; c++) begin
      if (stalled) begin
        chk("stall out_valid held", 128'(ov), 128'(1));
        chk("stall data held", dout, held);
      end
      ordy = ($urandom_range(0, 9) >= 3);
      if (acc_n < 64 && $urandom_range(0, 9) < 6) begin
        p = {$urandom, $urandom, $urandom, $urandom};
        iv = 1'b1; din = enc(p, ks14, 14);
      end else begin
        iv = 1'b0; din = {$urandom, $urandom, $urandom, $urandom};
      end
`ifdef AES_DEC_TAG_EN
      tg_in = 8'(acc_n);
`endif
      #1;
      chk("in_ready equation", 128'(ir), 128'(!ov || ordy));
      if (ov && ordy) begin
        chk("stall data", dout, q.pop_front());
`ifdef AES_DEC_TAG_EN
        chk("stall tag", 128'(tg_out), 128'(tq.pop_front()));
`endif
      end
      if (iv && ir) begin
        q.push_back(p);
        tq.push_back(8'(acc_n));
        acc_n++;
      end
      stalled = ov && !ordy;
      held = dout;
      @(posedge clk); #1;
    end
    iv = 1'b0; ordy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ov) begin
        chk("drain data", dout, q.pop_front());
`ifdef AES_DEC_TAG_EN
        chk("drain tag", 128'(tg_out), 128'(tq.pop_front()));
`endif
      end
      @(posedge clk); #1;
    end
    chk("stall accepted", 128'(acc_n), 128'(64));
    chk("stall leftover", 128'(q.size()), 128'(0));
    chk("drain busy", 128'(bsy), 128'(0));

    // Reset with 5 blocks in flight, head block stalled at the output
    ordy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      iv = 1'b1; din = enc({$urandom, $urandom, $urandom, $urandom}, ks14, 14);
      @(posedge clk); #1;
    end
    iv = 1'b0;
    for (int c = 0; c < 30 && !ov; c++) begin @(posedge clk); #1; end
    chk("pre-reset out_valid", 128'(ov), 128'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 128'(ov), 128'(0));
    chk("async reset data_out", dout, '0);
    chk("async reset busy", 128'(bsy), 128'(0));
    chk("async reset in_ready", 128'(ir), 128'(1));
`ifdef AES_DEC_TAG_EN
    chk("async reset tag_out", 128'(tg_out), 128'(0));
`endif
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    ordy = 1'b1; stale = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (ov) stale++;
    end
    chk("post-reset stale beats", 128'(stale), 128'(0));
    @(negedge clk); iv = 1'b1; din = CT14; lat14 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) iv = 1'b0;
      if (ov && lat14 == 0) begin lat14 = c; got14 = dout; end
    end
    chk("post-reset latency", 128'(lat14), 128'(15));
    chk("post-reset pt", got14, PT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
